// File: rtl/dps_pkg.sv
// Shared types and width helpers for the descending part-select reader/writer pair.
package dps_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } dps_state_e;

  // Default beat width: WIDTH / SELW^2.
  function automatic int slice_w(input int width, input int selw);
    return width / (selw * selw);
  endfunction

  // Signed pointer width: full ctrl*sel product plus headroom for WIDTH and sign.
  function automatic int idx_w(input int ctrlw, input int selw);
    return ctrlw + selw + 2;
  endfunction

endpackage

// File: rtl/dps_slice_reader_if.sv
// Load and beat handshake bundle between the register bank, the reader and the consumer.
interface dps_slice_reader_if
  import dps_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SELW  = 4,
  parameter int CTRLW = $clog2(WIDTH),
  parameter int SLICE = slice_w(WIDTH, SELW)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic [CTRLW-1:0] ctrl;
  logic [SELW-1:0]  sel;
  logic             out_valid;
  logic             out_ready;
  logic [SLICE-1:0] out_data;
  logic             out_last;
  logic             err;

  modport slave (
    input  in_valid, in_word, ctrl, sel, out_ready,
    output in_ready, out_valid, out_data, out_last, err
  );

  modport master (
    output in_valid, in_word, ctrl, sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/dps_slice_extract.sv
// Combinational descending part-select word[p -: SLICE]; bits outside the word read as 0.
module dps_slice_extract #(
  parameter int WIDTH = 32,
  parameter int SLICE = 2,
  parameter int IW    = 11
) (
  input  logic [WIDTH-1:0]     word,
  input  logic signed [IW-1:0] p,
  output logic [SLICE-1:0]     slice
);
  localparam int EW = WIDTH + 2 * SLICE;
  localparam logic signed [IW:0] SH_MAX = (IW + 1)'(WIDTH + SLICE);

  logic [EW-1:0]     ext;
  logic [EW-1:0]     shifted;
  logic signed [IW:0] sh;

  // Word is padded by SLICE zeros on both sides, so slice bit k lands at ext[p+1+k].
  always_comb begin
    ext     = {{SLICE{1'b0}}, word, {SLICE{1'b0}}};
    sh      = (IW + 1)'(p) + (IW + 1)'(1);
    shifted = ext >> $unsigned(sh);
    slice   = shifted[SLICE-1:0];
    if (sh[IW] || (sh > SH_MAX)) slice = '0;
  end
endmodule

// File: rtl/dps_slice_reader.sv
// Loads a word with ctrl/sel, then streams word[p -: SLICE] beats from p = WIDTH - ctrl*sel down to bit 0.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a load; a negative top index pulses err
// STREAM | out_valid high, emitting beats until the one holding bit 0 is accepted
module dps_slice_reader
  import dps_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SELW  = 4,
  parameter int CTRLW = $clog2(WIDTH),
  parameter int SLICE = slice_w(WIDTH, SELW)
) (
  input  logic              clk,
  input  logic              rst_n,
  dps_slice_reader_if.slave bus
);
  localparam int PW = CTRLW + SELW;
  localparam int IW = idx_w(CTRLW, SELW);
  localparam logic signed [IW-1:0] SLICE_S = IW'(SLICE);
  localparam logic signed [IW-1:0] WIDTH_S = IW'(WIDTH);

  if (SLICE < 1) begin : g_slice_chk
    $error("dps_slice_reader: SLICE must be >= 1");
  end

  dps_state_e          state_q, state_d;
  logic signed [IW-1:0] p_q, p_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [SLICE-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                err_q, err_d;

  logic [PW-1:0]       prod;
  logic signed [IW-1:0] top_s;
  logic [SLICE-1:0]    slice_nxt;

  // Beats are extracted from the next-state pointer so every output comes straight off a flop.
  dps_slice_extract #(
    .WIDTH (WIDTH),
    .SLICE (SLICE),
    .IW    (IW)
  ) u_extract (
    .word  (word_d),
    .p     (p_d),
    .slice (slice_nxt)
  );

  always_comb begin
    prod  = PW'(bus.ctrl) * PW'(bus.sel);
    top_s = WIDTH_S - $signed({2'b00, prod});

    state_d = state_q;
    p_d     = p_q;
    word_d  = word_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d = bus.in_word;
          if (top_s[IW-1]) begin
            err_d = 1'b1;
          end else begin
            p_d     = top_s;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (out_last_q) state_d = IDLE;
          else            p_d     = p_q - SLICE_S;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == STREAM);
    out_last_d  = (state_d == STREAM) && (p_d < SLICE_S);
    out_data_d  = (state_d == STREAM) ? slice_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;
endmodule
